// File: rtl/issue_stage_pkg.sv
// Shared datapath width, ALU op codes, instruction field positions and
// pipeline slot type for the 16-bit CPU issue stage.
package issue_stage_pkg;

   localparam int DSIZE = 16;
   localparam int NREG  = 16;
   localparam int RW    = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_SLL = 3'd4,
      OP_SRL = 3'd5,
      OP_SRA = 3'd6,
      OP_RL  = 3'd7
   } alu_op_e;

   localparam int F_LDI    = 15;
   localparam int F_OP_HI  = 14;
   localparam int F_OP_LO  = 12;
   localparam int F_RD_HI  = 11;
   localparam int F_RD_LO  = 8;
   localparam int F_RS1_HI = 7;
   localparam int F_RS1_LO = 4;
   localparam int F_RS2_HI = 3;
   localparam int F_RS2_LO = 0;

   typedef struct packed {
      logic          valid;
      logic [RW-1:0] rd;
   } slot_t;

   // Register-register ops have op[2]=0; shifts/rotates use an immediate instead of rs2.
   function automatic logic op_uses_rs2(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/issue_stage_reg_file.sv
// 16x16 register file: two combinational read ports, one synchronous write port,
// R0 hardwired to zero, synchronous active-low clear.
module reg_file
   import issue_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [RW-1:0]    ra1,
   input  logic [RW-1:0]    ra2,
   output logic [DSIZE-1:0] rd1,
   output logic [DSIZE-1:0] rd2,
   input  logic             we,
   input  logic [RW-1:0]    wa,
   input  logic [DSIZE-1:0] wd
);

   logic [DSIZE-1:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
   assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/issue_stage.sv
// Decode/operand issue ahead of a 1-cycle ALU: accept -> alu_* next cycle -> writeback one later.
// instr_ready drops for one cycle when the instruction reads the register issued last cycle.
module issue_stage
   import issue_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   input  logic [15:0]      instr,
   output logic             instr_ready,
   output logic [DSIZE-1:0] alu_a,
   output logic [DSIZE-1:0] alu_b,
   output logic [2:0]       alu_op,
   output logic [3:0]       alu_imm,
   input  logic [DSIZE-1:0] alu_out,
   input  logic [2:0]       alu_flag,
   output logic [2:0]       status,
   output logic             wb_valid,
   output logic [RW-1:0]    wb_rd
);

   logic             is_ldi;
   logic [2:0]       op;
   logic [RW-1:0]    rd, rs1, rs2;
   logic             use1, use2, hazard, accept;
   logic [DSIZE-1:0] rf_rd1, rf_rd2, opnd1, opnd2;
   logic [DSIZE-1:0] a_nxt, b_nxt;
   logic [2:0]       op_nxt;
   logic [3:0]       imm_nxt;
   slot_t            ex_q, wb_q;

   assign is_ldi = instr[F_LDI];
   assign op     = instr[F_OP_HI:F_OP_LO];
   assign rd     = instr[F_RD_HI:F_RD_LO];
   assign rs1    = instr[F_RS1_HI:F_RS1_LO];
   assign rs2    = instr[F_RS2_HI:F_RS2_LO];
   assign use1   = ~is_ldi;
   assign use2   = ~is_ldi & op_uses_rs2(op);

   // The WB-slot result is forwardable, so only the EX slot can force a stall.
   assign hazard = instr_valid & ex_q.valid & (ex_q.rd != '0) &
                   ((use1 & (rs1 == ex_q.rd)) | (use2 & (rs2 == ex_q.rd)));
   assign instr_ready = ~hazard;
   assign accept      = instr_valid & instr_ready;

   function automatic logic [DSIZE-1:0] pick(input logic [RW-1:0] rs, input logic [DSIZE-1:0] rf,
                                             input slot_t wb, input logic [DSIZE-1:0] fwd);
      if (rs == '0)                  return '0;
      else if (wb.valid && wb.rd == rs) return fwd;
      else                           return rf;
   endfunction

   assign opnd1 = pick(rs1, rf_rd1, wb_q, alu_out);
   assign opnd2 = pick(rs2, rf_rd2, wb_q, alu_out);

   reg_file u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (rs1),
      .ra2   (rs2),
      .rd1   (rf_rd1),
      .rd2   (rf_rd2),
      .we    (wb_q.valid),
      .wa    (wb_q.rd),
      .wd    (alu_out)
   );

   always_comb begin
      a_nxt   = '0;
      b_nxt   = '0;
      op_nxt  = OP_ADD;
      imm_nxt = '0;
      if (accept) begin
         if (is_ldi) begin
            a_nxt = {{(DSIZE-8){instr[7]}}, instr[7:0]};
         end else begin
            a_nxt  = opnd1;
            op_nxt = op;
            if (use2) b_nxt   = opnd2;
            else      imm_nxt = rs2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_op  <= OP_ADD;
         alu_imm <= '0;
         status  <= '0;
         ex_q    <= '0;
         wb_q    <= '0;
      end else begin
         alu_a    <= a_nxt;
         alu_b    <= b_nxt;
         alu_op   <= op_nxt;
         alu_imm  <= imm_nxt;
         ex_q     <= accept ? slot_t'{valid: 1'b1, rd: rd} : '0;
         wb_q     <= ex_q;
         // Flags retire even when the destination is R0.
         if (wb_q.valid) status <= alu_flag;
      end
   end

   assign wb_valid = wb_q.valid;
   assign wb_rd    = wb_q.rd;

endmodule

// File: doc/issue_stage.md
# issue_stage

Decode, register-file and operand-issue stage of the 16-bit CPU, sitting directly upstream of the ALU. It accepts one 16-bit instruction per cycle through a valid/ready handshake and reads operands from a 16×16 register file, forwarding from the ALU result where needed. It drives registered operands, op and shift amount into the ALU, then writes the ALU result and flags back after the ALU's one-cycle registered latency. A one-cycle interlock covers the back-to-back dependency that forwarding cannot cover.

## Interface
- `DSIZE`, 16, datapath width (shared define)
- `NREG`, 16, number of architectural registers; index width is 4
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `instr_valid`  in  1  instruction offered
- `instr`  in  16  instruction word
- `instr_ready`  out  1  instruction accepted this cycle when high with `instr_valid`
- `alu_a`, `alu_b`  out  16  registered ALU operands
- `alu_op`  out  3  registered ALU op (shared op codes)
- `alu_imm`  out  4  registered shift/rotate amount
- `alu_out`  in  16  registered ALU result
- `alu_flag`  in  3  registered ALU flags {n,v,z}
- `status`  out  3  architectural flag register {n,v,z}
- `wb_valid`  out  1  a register write retires this cycle
- `wb_rd`  out  4  destination of the retiring write

## Operation
- Instruction format, `instr[15]=0` (ALU type):
  - `[14:12]` ALU op, passed unchanged to `alu_op`
  - `[11:8]` rd, `[7:4]` rs1, `[3:0]` rs2 or imm
  - For ADD/SUB/AND/OR: A=R[rs1], B=R[rs2], imm=0.
  - For SLL/SRL/SRA/RL: A=R[rs1], B=0, imm=`instr[3:0]`.
- `instr[15]=1` is LDI:
  - rd=`[11:8]`; A=sign-extended `instr[7:0]`, B=0, op=ADD, imm=0.
  - The value passes through the ALU, so LDI updates flags.
- R0 reads as 0 and writes to it are discarded. R0 never causes a hazard or a forward.
- Pipeline tracking:
  - EX slot {valid, rd} holds the instruction issued last cycle.
  - WB slot {valid, rd} holds the instruction issued two cycles ago, whose result is on `alu_out` now.
- Hazard: `instr_ready=0` when `instr_valid`, EX.valid, EX.rd≠0, and EX.rd equals any source the instruction actually uses. LDI has no sources; shifts use rs1 only. `instr_ready` is otherwise 1 and may depend combinationally on `instr`.
- Operand read priority: R0 → 0; else WB match (WB.valid, WB.rd==rs) → `alu_out`; else register file.
- Writeback, when WB.valid:
  - R[WB.rd] ← `alu_out` (skipped if rd=0).
  - `status` ← `alu_flag` (including when rd=0).
  - `wb_valid`=1, `wb_rd`=WB.rd, combinationally from the WB slot.
- Bubble (no accept): issue registers load A=0, B=0, op=ADD, imm=0; EX.valid ← 0.

## Timing
- Accept in cycle c → `alu_*` valid in c+1 → `alu_out` in c+2 → register file and `status` updated at the end of c+2.
- Dependent instruction:
  - Offered at c+1: stalls exactly 1 cycle.
  - At c+2: forwarded from `alu_out`.
  - At ≥c+3: read from the register file.
- Throughput is 1 instruction per cycle with no dependencies.
- A same-cycle writeback and read of the same register returns the new value (forward path).
- Reset values: `alu_a`=`alu_b`=0, `alu_op`=ADD, `alu_imm`=0, `status`=0, `instr_ready`=1, `wb_valid`=0, `wb_rd`=0. All R[i]=0; EX and WB invalid.
- Reset mid-operation: in-flight EX/WB instructions are dropped with no register write, and there is no stall after reset releases.

## Structure
- Shared define file: `DSIZE`, ALU op codes, instruction field positions, LDI opcode bit, `NREG`.
- One sub-module, `reg_file`: 16×16, two combinational read ports, one synchronous write port, R0 hardwired to zero, synchronous active-low clear.
- Hazard, forward and issue logic live in `issue_stage`.

## Test plan
- Reset: hold `rst_n` low 2 cycles → all outputs at reset values; ADD r1,r1,r1 issued afterwards writes 0.
- Independent: LDI r1,5; LDI r2,3; NOP-bubble; ADD r3,r1,r2 → r3=8 at c+2, no stall, `status`=000.
- Interlock: LDI r1,0x7F then ADD r2,r1,r1 next cycle → `instr_ready` low for exactly 1 cycle; r2=0x00FE.
- Forward/zero flag: LDI r1,1; LDI r4,2; SUB r2,r1,r1 → no stall, r1 taken from `alu_out`, r2=0, `status.z`=1.
- Shifts/sign-extend: LDI r1,0x80 → r1=0xFF80 with `status.n`=1; then SRA r2,r1,#4 → r2=0xFFF8; RL r3,r1,#4 → r3=0xF80F.
- R0 and mid-reset: LDI r0,5 then ADD r1,r0,r0 → r1=0, no stall. LDI r5,9 followed by `rst_n` low next cycle → r5 stays 0.
